// File: rtl/wallace_pkg.sv
// rtl/wallace_pkg.sv - shared constants and CSA tree sizing helpers for the Wallace multiplier
package wallace_pkg;

    localparam int   LATENCY       = 3;
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // One 3:2 level turns every full group of three rows into two; leftovers pass through.
    function automatic int csa_rows_next(input int rows);
        return 2 * (rows / 3) + (rows % 3);
    endfunction

    function automatic int csa_rows_at(input int rows, input int level);
        int n;
        n = rows;
        for (int l = 0; l < level; l++) begin
            n = csa_rows_next(n);
        end
        return n;
    endfunction

    function automatic int csa_levels(input int rows);
        int n;
        int lv;
        n  = rows;
        lv = 0;
        while (n > 2) begin
            n  = csa_rows_next(n);
            lv = lv + 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/csa_row.sv
// rtl/csa_row.sv - W-bit 3:2 carry-save compressor row with carry pre-shifted one place left
module csa_row #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] maj;

    assign sum_o   = a_i ^ b_i ^ c_i;
    assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    // The carry out of the top bit falls off: the product is exact in W bits.
    assign carry_o = maj << 1;

endmodule

// File: rtl/wallace_mult_pipe.sv
// rtl/wallace_mult_pipe.sv - 3-stage Wallace-tree multiplier, signed/unsigned per transaction
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW     = 2 * WIDTH;
    localparam int NROWS  = WIDTH + 1;
    localparam int LEVELS = csa_levels(NROWS);
    localparam logic [PW-1:0] BW_CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic v1_q, v2_q, v3_q;
    logic load1, load2, load3;

    assign load3    = ~v3_q | out_ready;
    assign load2    = ~v2_q | load3;
    assign load1    = ~v1_q | load2;
    assign in_ready = load1 & ~rst;

    // Baugh-Wooley: complement the cross terms that involve exactly one sign bit.
    logic [PW-1:0] pp_d [NROWS];
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        localparam logic [WIDTH-1:0] MASK_ROW = (i == WIDTH - 1) ?
            {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        logic [WIDTH-1:0] bits;
        assign bits    = (in_a & {WIDTH{in_b[i]}}) ^ ((in_signed == MODE_SIGNED) ? MASK_ROW : '0);
        assign pp_d[i] = PW'(bits) << i;
    end
    assign pp_d[WIDTH] = (in_signed == MODE_SIGNED) ? BW_CORR : '0;

    logic [PW-1:0]    pp_q [NROWS];
    logic [TAG_W-1:0] tag1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else begin
            if (load1) v1_q <= in_valid;
            if (load1 && in_valid) begin
                pp_q   <= pp_d;
                tag1_q <= in_tag;
            end
        end
    end

    logic [PW-1:0] tree [LEVELS+1][NROWS];
    for (genvar r = 0; r < NROWS; r++) begin : g_lvl0
        assign tree[0][r] = pp_q[r];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N  = csa_rows_at(NROWS, l);
        localparam int G  = N / 3;
        localparam int NN = csa_rows_next(N);
        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_row #(.W(PW)) u_csa (
                .a_i     (tree[l][3*g]),
                .b_i     (tree[l][3*g+1]),
                .c_i     (tree[l][3*g+2]),
                .sum_o   (tree[l+1][2*g]),
                .carry_o (tree[l+1][2*g+1])
            );
        end
        for (genvar k = 0; k < N % 3; k++) begin : g_pass
            assign tree[l+1][2*G+k] = tree[l][3*G+k];
        end
        for (genvar r = NN; r < NROWS; r++) begin : g_zero
            assign tree[l+1][r] = '0;
        end
    end

    logic [PW-1:0]    sum_q, carry_q;
    logic [TAG_W-1:0] tag2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else begin
            if (load2) v2_q <= v1_q;
            if (load2 && v1_q) begin
                sum_q   <= tree[LEVELS][0];
                carry_q <= tree[LEVELS][1];
                tag2_q  <= tag1_q;
            end
        end
    end

    logic [PW-1:0]    p_q;
    logic [TAG_W-1:0] tag3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            p_q    <= '0;
            tag3_q <= '0;
        end else begin
            if (load3) v3_q <= v2_q;
            if (load3 && v2_q) begin
                p_q    <= sum_q + carry_q;
                tag3_q <= tag2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_p     = p_q;
    assign out_tag   = tag3_q;

endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a  input  WIDTH  multiplicand.
REQ-008 in_b  input  WIDTH  multiplier.
REQ-009 in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled per transaction.
REQ-010 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_p  output  2*WIDTH  full-width product.
REQ-014 out_tag  output  TAG_W  tag of the transaction in out_p.

Function
REQ-015 Transfer on input when in_valid & in_ready at a rising edge; transfer on output when out_valid & out_ready.
REQ-016 Three register stages: S1 = partial products (sign-corrected), S2 = CSA reduction down to two rows, S3 = final carry-propagate sum; latency 3 cycles from input transfer to out_valid, with no stalls.
REQ-017 Each stage holds a valid bit; a stage loads when it is empty or when its downstream stage loads (bubble-collapsing); in_ready = ~v1 | S1 loads.
REQ-018 in_ready is combinational from out_ready and the stage valid bits only, never from in_valid.
REQ-019 With out_ready held high, throughput is one result per cycle.
REQ-020 With out_ready low and all three stages full, in_ready = 0; out_p, out_tag and out_valid stay stable until transferred.
REQ-021 Unsigned mode: out_p = in_a * in_b, exact, 2*WIDTH bits, no truncation.
REQ-022 Signed mode: out_p = two's-complement exact product via Baugh-Wooley correction terms in S1; no overflow is possible at 2*WIDTH bits.
REQ-023 Mode is carried per transaction through the pipe, so mixed signed/unsigned back-to-back transfers are legal.
REQ-024 Reduction in S2 uses only 3:2 carry-save rows with carry shifted left one bit; bits above 2*WIDTH-1 are discarded.
REQ-025 Simultaneous output transfer and input transfer with a full pipe is legal and loses no data.
REQ-026 out_p and out_tag are don't-care when out_valid = 0, but shall equal the last transferred values (no X propagation).

Reset
REQ-027 While rst = 1 at a rising edge, all stage valid bits clear; out_valid = 0, out_p = 0 and out_tag = 0 after that edge.
REQ-028 in_ready = 0 while rst is high; after reset, in_ready = 1 on the first cycle.
REQ-029 Reset mid-operation discards all in-flight transactions; no result for them is ever presented.

Structure
REQ-030 Shared package wallace_pkg holds: the LATENCY = 3 constant; the mode encodings MODE_UNSIGNED = 0 and MODE_SIGNED = 1; and a function computing the number of CSA levels for a given row count.
REQ-031 One sub-module, csa_row: a parametrised-width 3:2 compressor row that outputs sum and shifted carry; S2 instantiates it in a generate-built tree.
REQ-032 The final adder in S3 is behavioural "+" on two 2*WIDTH rows; there is no separate adder module.

Verification (WIDTH=16, TAG_W=4)
REQ-033 Unsigned 0xFFFF x 0xFFFF, tag 0x3, out_ready = 1 -> out_valid exactly 3 cycles later, out_p = 0xFFFE0001, out_tag = 0x3.
REQ-034 Signed 0x8000 x 0x8000 -> 0x40000000; signed 0x8000 x 0x7FFF -> 0xC0008000; signed 0xFFFF x 0xFFFF -> 0x00000001; the same 0xFFFF x 0xFFFF unsigned in the next cycle -> 0xFFFE0001.
REQ-035 Stream of 8 back-to-back transfers, out_ready = 0 for cycles 4-9 -> in_ready falls once 3 are held, no loss or duplication, results in order with matching tags.
REQ-036 Full pipe, out_ready = 1 and in_valid = 1 in the same cycle -> one output and one input transfer in that cycle, pipe stays full.
REQ-037 rst asserted for one cycle with 2 transactions in flight -> out_valid = 0 and out_p = 0 after the edge; neither result ever appears.
REQ-038 Random test, 10000 transfers, random mode and random backpressure -> every out_p matches the signed/unsigned reference model, in order.
